// File: rtl/i2c_master_driver_if.sv
// Handshake bundle between the pass sequencer (master modport) and the I2C
// bit-level core (slave modport).
interface i2c_master_driver_if;
  logic       ready;
  logic       start;
  logic       send;
  logic [7:0] datasend;
  logic       sended;
  logic       received;
  logic [7:0] datareceive;
  logic       nack;
  logic       more;

  modport master (
    input  ready, send, received, datareceive, nack,
    output start, datasend, sended, more
  );

  modport slave (
    output ready, send, received, datareceive, nack,
    input  start, datasend, sended, more
  );
endinterface

// File: rtl/i2c_master_driver.sv
// Write-then-read-back pass sequencer for the I2C master with pass/error counters.
// I2C_MASTER_DRIVER_LOOP_EN: when defined, passes repeat back to back after one go.
module i2c_master_driver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter int         NBYTES     = 4,
  parameter int         GAP        = 1000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                go_i,
  i2c_master_driver_if.master bus,
  output logic                busy_o,
  output logic [7:0]          pass_cnt_o,
  output logic [7:0]          err_cnt_o,
  output logic [7:0]          last_byte_o
);

  // state    | meaning
  // IDLE     | waiting for go
  // W_START  | waiting for ready, then start the write transaction
  // W_ADDR   | answer send with the write address byte
  // W_DATA   | answer send with seed+idx
  // R_WAIT   | waiting for ready before the read transaction
  // R_START  | start pulse of the read transaction is on the bus
  // R_ADDR   | answer send with the read address byte
  // R_DATA   | collect and compare received bytes
  // GAP_WAIT | idle spacing between passes
  typedef enum logic [3:0] {
    IDLE, W_START, W_ADDR, W_DATA, R_WAIT, R_START, R_ADDR, R_DATA, GAP_WAIT
  } state_t;

  localparam int         GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    seed_q, seed_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    datasend_q, datasend_d;
  logic          sended_q, sended_d;
  logic          start_q, start_d;
  logic [7:0]    pass_q, pass_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    last_q, last_d;
  logic          bad_q, bad_d;

  logic [7:0] expect_byte;
  logic       nack_abort;
  logic       mismatch;
  logic       more;

  assign expect_byte = seed_q + {4'b0000, idx_q};
  assign mismatch    = (bus.datareceive != expect_byte);
  assign nack_abort  = bus.nack && (state_q inside {W_ADDR, W_DATA, R_WAIT, R_START, R_ADDR, R_DATA});

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seed_d     = seed_q;
    gap_d      = gap_q;
    datasend_d = datasend_q;
    sended_d   = 1'b0;
    start_d    = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    last_d     = last_q;
    bad_d      = bad_q;

    case (state_q)
      IDLE: begin
        if (go_i) begin
          state_d = W_START;
          idx_d   = 4'd0;
          bad_d   = 1'b0;
        end
      end
      W_START: begin
        if (bus.ready) begin
          start_d = 1'b1;
          state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (bus.send) begin
          datasend_d = {SLAVE_ADDR, 1'b0};
          sended_d   = 1'b1;
          state_d    = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.send) begin
          datasend_d = expect_byte;
          sended_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = R_WAIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      R_WAIT: begin
        if (bus.ready) begin
          start_d = 1'b1;
          state_d = R_START;
        end
      end
      R_START: state_d = R_ADDR;
      R_ADDR: begin
        if (bus.send) begin
          datasend_d = {SLAVE_ADDR, 1'b1};
          sended_d   = 1'b1;
          idx_d      = 4'd0;
          state_d    = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.received) begin
          last_d = bus.datareceive;
          if (mismatch) begin
            bad_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
          if (idx_q == LAST_IDX) begin
            if (!bad_q && !mismatch && pass_q != 8'hFF) pass_d = pass_q + 8'd1;
            gap_d   = GAP_LOAD;
            state_d = GAP_WAIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      GAP_WAIT: begin
        if (gap_q == '0) begin
          seed_d = seed_q + 8'd1;
`ifdef I2C_MASTER_DRIVER_LOOP_EN
          state_d = W_START;
          idx_d   = 4'd0;
          bad_d   = 1'b0;
`else
          state_d = IDLE;
`endif
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A NACK overrides whatever the current state would have done this cycle.
    if (nack_abort) begin
      state_d    = GAP_WAIT;
      gap_d      = GAP_LOAD;
      idx_d      = idx_q;
      datasend_d = datasend_q;
      sended_d   = 1'b0;
      start_d    = 1'b0;
      pass_d     = pass_q;
      last_d     = last_q;
      bad_d      = 1'b1;
      err_d      = (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      seed_q     <= 8'h00;
      gap_q      <= '0;
      datasend_q <= 8'h00;
      sended_q   <= 1'b0;
      start_q    <= 1'b0;
      pass_q     <= 8'h00;
      err_q      <= 8'h00;
      last_q     <= 8'h00;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seed_q     <= seed_d;
      gap_q      <= gap_d;
      datasend_q <= datasend_d;
      sended_q   <= sended_d;
      start_q    <= start_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      last_q     <= last_d;
      bad_q      <= bad_d;
    end
  end

  // more describes the byte the master is about to move next.
  always_comb begin
    more = 1'b0;
    case (state_q)
      W_ADDR:  more = 1'b1;
      W_DATA:  more = (idx_q != LAST_IDX);
      R_ADDR:  more = 1'b1;
      R_DATA:  more = (idx_q != LAST_IDX);
      default: more = 1'b0;
    endcase
  end

  assign bus.start    = start_q;
  assign bus.datasend = datasend_q;
  assign bus.sended   = sended_q;
  assign bus.more     = more;

  assign busy_o      = (state_q != IDLE);
  assign pass_cnt_o  = pass_q;
  assign err_cnt_o   = err_q;
  assign last_byte_o = last_q;

endmodule
